// File: rtl/dds_freq_meter.sv
// Frequency meter for a signed sine sample stream: counts samples over 2^NP_LOG2
// hysteresis-qualified rising zero crossings, then divides to a DDS phase increment.
module dds_freq_meter #(
    parameter int          PHASE_WIDTH = 32,
    parameter int          NP_LOG2     = 4,
    parameter int          CNT_WIDTH   = 24,
    parameter logic [15:0] HYST        = 16'd256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sample_valid,
    input  logic signed [15:0]      sample_in,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [PHASE_WIDTH-1:0]  delta_phase_est
);

    localparam int DIV_BITS = PHASE_WIDTH + NP_LOG2 + 1;
    localparam int BC_W     = $clog2(DIV_BITS + 1);
    localparam logic [BC_W-1:0]      LAST_STEP = BC_W'(DIV_BITS - 1);
    localparam logic [NP_LOG2:0]     XC_LAST   = {1'b0, {NP_LOG2{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] SC_LIMIT  = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
    localparam int                   NEG_HYST  = -int'(HYST);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_DIVIDE  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]             state_q,   state_d;
    logic                   armed_q,   armed_d;
    logic [NP_LOG2:0]       xcount_q,  xcount_d;
    logic [CNT_WIDTH-1:0]   scount_q,  scount_d;
    logic [CNT_WIDTH-1:0]   rem_q,     rem_d;
    logic [DIV_BITS-2:0]    quot_q,    quot_d;
    logic [BC_W-1:0]        step_q,    step_d;
    logic [PHASE_WIDTH-1:0] est_q,     est_d;
    logic                   timeout_q, timeout_d;

    logic                   belowArm;
    logic                   crossing;
    logic                   atLimit;
    logic [CNT_WIDTH:0]     trial;
    logic [CNT_WIDTH-1:0]   diff;
    logic                   fits;
    logic [DIV_BITS-1:0]    quotNext;

    // The dividend is a single 1 followed by zeros, so only the first step shifts in a 1.
    assign belowArm = int'(sample_in) < NEG_HYST;
    assign crossing = armed_q && !sample_in[15];
    assign atLimit  = (scount_q == SC_LIMIT);
    assign trial    = {rem_q, step_q == '0};
    assign fits     = trial >= {1'b0, scount_q};
    assign diff     = trial[CNT_WIDTH-1:0] - scount_q;
    assign quotNext = {quot_q, fits};

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        xcount_d  = xcount_q;
        scount_d  = scount_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        step_d    = step_q;
        est_d     = est_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ARM;
                    armed_d  = 1'b0;
                    xcount_d = '0;
                    scount_d = '0;
                end
            end
            S_ARM, S_MEASURE: begin
                if (sample_valid) begin
                    if (atLimit) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        est_d     = '0;
                    end else begin
                        armed_d = belowArm ? 1'b1 : (crossing ? 1'b0 : armed_q);
                        if (state_q == S_ARM) begin
                            if (crossing) begin
                                state_d  = S_MEASURE;
                                scount_d = '0;
                                xcount_d = '0;
                            end else begin
                                scount_d = scount_q + 1'b1;
                            end
                        end else begin
                            scount_d = scount_q + 1'b1;
                            if (crossing) begin
                                xcount_d = xcount_q + 1'b1;
                                if (xcount_q == XC_LAST) begin
                                    state_d = S_DIVIDE;
                                    rem_d   = '0;
                                    quot_d  = '0;
                                    step_d  = '0;
                                end
                            end
                        end
                    end
                end
            end
            S_DIVIDE: begin
                rem_d  = fits ? diff : trial[CNT_WIDTH-1:0];
                quot_d = quotNext[DIV_BITS-2:0];
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    est_d     = (|quotNext[DIV_BITS-1:PHASE_WIDTH]) ? '1
                                                                    : quotNext[PHASE_WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                timeout_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            xcount_q  <= '0;
            scount_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            step_q    <= '0;
            est_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            xcount_q  <= xcount_d;
            scount_q  <= scount_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            step_q    <= step_d;
            est_q     <= est_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign timeout         = timeout_q;
    assign delta_phase_est = est_q;

endmodule
